// File: rtl/full_src.sv
// ---------------------------------------------------------------------------
// full_src
//
// Stream transmitter feeding the network input stream (data / fst / vld / rdy).
// A host preloads a small sample buffer while the block is idle, then issues a
// one-cycle start command. The block emits frame_len words from the buffer,
// repeated (repeat_cnt + 1) times. The first word of every frame is marked
// with st_data_fst. Transfers happen on every edge where vld && rdy.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   wr_en        buffer write strobe (ignored while busy)
//   wr_addr      buffer write address
//   wr_data      buffer write data (float_24_8 packing, opaque here)
//   frame_len    words per frame, sampled on start, clamped to DEPTH
//   repeat_cnt   extra frames after the first, sampled on start
//   start        one-cycle start command (ignored unless idle)
//   busy         high from the accepted start until done
//   done         one-cycle pulse at the end of a command
//   st_data      stream data (registered)
//   st_data_fst  first word of frame (registered, only ever set with vld)
//   st_data_vld  stream valid (registered)
//   st_data_rdy  downstream ready
// ---------------------------------------------------------------------------
module full_src #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic [7:0]            repeat_cnt,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_data_fst,
  output logic                  st_data_vld,
  input  logic                  st_data_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0]   LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

  // Sample buffer; contents deliberately survive reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [7:0]            frames_left_q;
  logic                  word_left_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  fst_q;
  logic                  vld_q;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic [ADDR_WIDTH:0]   len_last;
  logic                  last_in_frame;
  logic                  load_en;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] idx_d;
  logic [7:0]            frames_left_d;
  logic                  word_left_d;

  // Host writes land only while idle so a running command sees a frozen buffer.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Frame length is clamped once at start so the index compare never has to
  // consider lengths the buffer cannot hold.
  always_comb begin
    len_clamped = (frame_len > LEN_MAX) ? LEN_MAX : frame_len;
  end

  // Index bookkeeping for the next load. The last word of a frame wraps the
  // index and consumes one of the remaining repeats; when none remain, the
  // word being loaded is the final one of the whole command.
  always_comb begin
    len_last      = len_q - LEN_ONE;
    last_in_frame = ({1'b0, idx_q} == len_last);
    idx_d         = last_in_frame ? '0 : (idx_q + IDX_ONE);
    frames_left_d = frames_left_q;
    word_left_d   = word_left_q;
    if (last_in_frame) begin
      if (frames_left_q != 8'd0) begin
        frames_left_d = frames_left_q - 8'd1;
      end else begin
        word_left_d = 1'b0;
      end
    end
  end

  // The output register refills whenever it is empty or being drained, which
  // keeps one word per cycle under rdy=1, even across frame boundaries.
  always_comb begin
    xfer    = vld_q && st_data_rdy;
    load_en = (state_q == S_SEND) && word_left_q && (!vld_q || st_data_rdy);
  end

  // Control FSM and registered stream outputs.
  // DONE is entered two ways: from SEND with done already raised (lasts one
  // cycle), or straight from IDLE for a zero-length command with done still
  // low, in which case DONE raises done on its first edge and leaves on the
  // next. Both paths give a single one-cycle done pulse with busy low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      frames_left_q <= '0;
      word_left_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      data_q        <= '0;
      fst_q         <= 1'b0;
      vld_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q         <= len_clamped;
            frames_left_q <= repeat_cnt;
            idx_q         <= '0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            if (len_clamped == '0) begin
              word_left_q <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              word_left_q <= 1'b1;
              state_q     <= S_SEND;
            end
          end
        end

        S_SEND: begin
          if (load_en) begin
            data_q        <= mem_q[idx_q];
            fst_q         <= (idx_q == '0);
            vld_q         <= 1'b1;
            idx_q         <= idx_d;
            frames_left_q <= frames_left_d;
            word_left_q   <= word_left_d;
          end else if (xfer) begin
            vld_q <= 1'b0;
            fst_q <= 1'b0;
            // Nothing left to load, so this handshake moved the final word.
            if (!word_left_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        S_DONE: begin
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign st_data     = data_q;
  assign st_data_fst = fst_q;
  assign st_data_vld = vld_q;

  // Protocol invariants that hold in every reachable state.
  a_fst_needs_vld : assert property (@(posedge clk) disable iff (!reset)
                                     st_data_fst |-> st_data_vld);
  a_done_not_busy : assert property (@(posedge clk) disable iff (!reset)
                                     done |-> !busy);

endmodule

// File: tb/tb_full_src.sv
// ---------------------------------------------------------------------------
// tb_full_src
//
// Self-checking bench for full_src. A behavioural model holds a copy of the
// sample buffer and expands each command into the expected word sequence
// (len words repeated repeat_cnt+1 times, first word of each frame flagged).
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_full_src;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   frame_len;
  logic [7:0]    repeat_cnt;
  logic          start;
  logic          busy;
  logic          done;
  logic [DW-1:0] st_data;
  logic          st_data_fst;
  logic          st_data_vld;
  logic          st_data_rdy;

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] modelMem [DEPTH];
  logic [DW-1:0] expData [$];
  bit            expFst [$];

  always #5 clk = ~clk;

  full_src #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_len(frame_len),
    .repeat_cnt(repeat_cnt),
    .start(start),
    .busy(busy),
    .done(done),
    .st_data(st_data),
    .st_data_fst(st_data_fst),
    .st_data_vld(st_data_vld),
    .st_data_rdy(st_data_rdy)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-time buffer write, mirrored into the model.
  task automatic writeWord(input int addr, input logic [DW-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr[AW-1:0];
    wr_data = data;
    tick();
    wr_en = 1'b0;
    modelMem[addr] = data;
  endtask

  // Expected stream for a command: clamp, then repeat the frame.
  function automatic void buildExpected(input int len, input int rep);
    int eff;
    eff = (len > DEPTH) ? DEPTH : len;
    expData.delete();
    expFst.delete();
    for (int f = 0; f <= rep; f++) begin
      for (int i = 0; i < eff; i++) begin
        expData.push_back(modelMem[i]);
        expFst.push_back(i == 0);
      end
    end
  endfunction

  // Present a start command for one edge; returns just after the accept edge.
  task automatic startCmd(input int len, input int rep);
    frame_len  = len[AW:0];
    repeat_cnt = rep[7:0];
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (st_data_vld !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld: got %b expected 0", st_data_vld); end
    checks++; if (st_data_fst !== 1'b0) begin fails++; $display("[TB] FAIL reset_fst: got %b expected 0", st_data_fst); end
    checks++; if (st_data !== '0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", st_data); end
    #2;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    writeWord(0, 32'h3F800000);
    writeWord(1, 32'h40000000);
    writeWord(2, 32'h40400000);
    writeWord(3, 32'h40800000);
    st_data_rdy = 1'b1;
    buildExpected(4, 0);
    startCmd(4, 0);
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy_accept: got %b expected 1", busy); end
    checks++; if (st_data_vld !== 1'b0) begin fails++; $display("[TB] FAIL basic_vld_accept: got %b expected 0", st_data_vld); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (st_data_vld !== 1'b1 || st_data !== expData[i] || st_data_fst !== expFst[i] || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("[TB] FAIL basic_word[%0d]: got vld=%b data=%h fst=%b busy=%b done=%b expected vld=1 data=%h fst=%b busy=1 done=0",
                 i, st_data_vld, st_data, st_data_fst, busy, done, expData[i], expFst[i]);
      end
    end
    tick();
    checks++;
    if (st_data_vld !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_done: got vld=%b done=%b busy=%b expected vld=0 done=1 busy=0", st_data_vld, done, busy);
    end
    tick();
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_repeat();
    int doneCount;
    st_data_rdy = 1'b1;
    buildExpected(4, 2);
    startCmd(4, 2);
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) doneCount++;
      checks++;
      if (st_data_vld !== 1'b1 || st_data !== expData[i] || st_data_fst !== expFst[i]) begin
        fails++;
        $display("[TB] FAIL repeat_word[%0d]: got vld=%b data=%h fst=%b expected vld=1 data=%h fst=%b",
                 i, st_data_vld, st_data, st_data_fst, expData[i], expFst[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) doneCount++;
      checks++; if (st_data_vld !== 1'b0) begin fails++; $display("[TB] FAIL repeat_tail_vld[%0d]: got %b expected 0", i, st_data_vld); end
    end
    checks++; if (doneCount != 1) begin fails++; $display("[TB] FAIL repeat_done_count: got %0d expected 1", doneCount); end
  endtask

  task automatic test_backpressure();
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int ti, cyc;
    bit doneSeen, sawVld;
    logic pv, pr, pf;
    logic [DW-1:0] pd;
    for (int a = 0; a < 3; a++) writeWord(a, $urandom);
    buildExpected(3, 0);
    st_data_rdy = (pat[0] != 0);
    startCmd(3, 0);
    pv = st_data_vld; pr = st_data_rdy; pd = st_data; pf = st_data_fst;
    ti = 0; cyc = 0; doneSeen = 0; sawVld = 0;
    while (!doneSeen && cyc < 100) begin
      tick();
      cyc++;
      if (pv && !pr) begin
        checks++;
        if (st_data_vld !== 1'b1 || st_data !== pd || st_data_fst !== pf) begin
          fails++;
          $display("[TB] FAIL bp_hold cyc=%0d: got vld=%b data=%h fst=%b expected vld=1 data=%h fst=%b",
                   cyc, st_data_vld, st_data, st_data_fst, pd, pf);
        end
      end
      if (pv && pr) begin
        checks++;
        if (ti >= expData.size()) begin
          fails++;
          $display("[TB] FAIL bp_extra_xfer: got transfer %0d expected at most %0d", ti + 1, expData.size());
        end else if (pd !== expData[ti] || pf !== expFst[ti]) begin
          fails++;
          $display("[TB] FAIL bp_xfer[%0d]: got data=%h fst=%b expected data=%h fst=%b", ti, pd, pf, expData[ti], expFst[ti]);
        end
        ti++;
      end
      if (st_data_vld === 1'b1) sawVld = 1;
      if (sawVld) begin
        checks++;
        if (st_data_vld !== (ti < expData.size())) begin
          fails++;
          $display("[TB] FAIL bp_vld cyc=%0d: got %b expected %b", cyc, st_data_vld, (ti < expData.size()));
        end
      end
      if (done === 1'b1) doneSeen = 1;
      st_data_rdy = (cyc < 6) ? (pat[cyc] != 0) : 1'b1;
      pv = st_data_vld; pr = st_data_rdy; pd = st_data; pf = st_data_fst;
    end
    checks++; if (!doneSeen) begin fails++; $display("[TB] FAIL bp_timeout: got no done expected done within 100 cycles"); end
    checks++; if (ti != 3) begin fails++; $display("[TB] FAIL bp_xfer_count: got %0d expected 3", ti); end
    tick();
  endtask

  task automatic test_zero_len();
    st_data_rdy = 1'b1;
    startCmd(0, 0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || st_data_vld !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_accept: got busy=%b done=%b vld=%b expected busy=1 done=0 vld=0", busy, done, st_data_vld);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || st_data_vld !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_done: got busy=%b done=%b vld=%b expected busy=0 done=1 vld=0", busy, done, st_data_vld);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || st_data_vld !== 1'b0) begin
        fails++;
        $display("[TB] FAIL zero_after[%0d]: got busy=%b done=%b vld=%b expected all 0", i, busy, done, st_data_vld);
      end
    end
  endtask

  task automatic test_write_during_send();
    for (int a = 0; a < 4; a++) writeWord(a, $urandom);
    st_data_rdy = 1'b1;
    buildExpected(4, 2);
    startCmd(4, 2);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (st_data_vld !== 1'b1 || st_data !== expData[i] || st_data_fst !== expFst[i]) begin
        fails++;
        $display("[TB] FAIL wds_word[%0d]: got vld=%b data=%h fst=%b expected vld=1 data=%h fst=%b",
                 i, st_data_vld, st_data, st_data_fst, expData[i], expFst[i]);
      end
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hDEADBEEF;
        frame_len = 5'd2; repeat_cnt = 8'd0; start = 1'b1;
      end else if (i == 3) begin
        wr_en = 1'b0; start = 1'b0;
      end
    end
    tick();
    checks++; if (done !== 1'b1) begin fails++; $display("[TB] FAIL wds_done: got %b expected 1", done); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || st_data_vld !== 1'b0) begin
        fails++;
        $display("[TB] FAIL wds_idle[%0d]: got busy=%b vld=%b expected busy=0 vld=0", i, busy, st_data_vld);
      end
    end
  endtask

  task automatic test_random_stream();
    for (int it = 0; it < 8; it++) begin
      int len, rep, ti, cyc;
      bit doneSeen;
      logic pv, pr, pf;
      logic [DW-1:0] pd;
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 1) == 1) writeWord(a, $urandom);
      end
      len = $urandom_range(1, 20);
      rep = $urandom_range(0, 3);
      buildExpected(len, rep);
      st_data_rdy = ($urandom_range(0, 99) < 60);
      startCmd(len, rep);
      checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rand_busy_accept it=%0d: got %b expected 1", it, busy); end
      pv = st_data_vld; pr = st_data_rdy; pd = st_data; pf = st_data_fst;
      ti = 0; cyc = 0; doneSeen = 0;
      while (!doneSeen && cyc < 2000) begin
        tick();
        cyc++;
        if (pv && !pr) begin
          checks++;
          if (st_data_vld !== 1'b1 || st_data !== pd || st_data_fst !== pf) begin
            fails++;
            $display("[TB] FAIL rand_hold it=%0d cyc=%0d: got vld=%b data=%h fst=%b expected vld=1 data=%h fst=%b",
                     it, cyc, st_data_vld, st_data, st_data_fst, pd, pf);
          end
        end
        if (pv && pr) begin
          checks++;
          if (ti >= expData.size()) begin
            fails++;
            $display("[TB] FAIL rand_extra it=%0d: got transfer %0d expected at most %0d", it, ti + 1, expData.size());
          end else if (pd !== expData[ti] || pf !== expFst[ti]) begin
            fails++;
            $display("[TB] FAIL rand_xfer it=%0d[%0d]: got data=%h fst=%b expected data=%h fst=%b",
                     it, ti, pd, pf, expData[ti], expFst[ti]);
          end
          ti++;
        end
        checks++;
        if (!st_data_vld && st_data_fst) begin
          fails++;
          $display("[TB] FAIL rand_fst_novld it=%0d: got fst=1 vld=0 expected fst=0", it);
        end
        if (done === 1'b1) begin
          doneSeen = 1;
          checks++;
          if (busy !== 1'b0 || st_data_vld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rand_done it=%0d: got busy=%b vld=%b expected busy=0 vld=0", it, busy, st_data_vld);
          end
        end else begin
          checks++;
          if (busy !== 1'b1) begin fails++; $display("[TB] FAIL rand_busy it=%0d cyc=%0d: got %b expected 1", it, cyc, busy); end
        end
        st_data_rdy = ($urandom_range(0, 99) < 60);
        pv = st_data_vld; pr = st_data_rdy; pd = st_data; pf = st_data_fst;
      end
      checks++; if (!doneSeen) begin fails++; $display("[TB] FAIL rand_timeout it=%0d: got no done expected done within 2000 cycles", it); end
      checks++; if (ti != expData.size()) begin fails++; $display("[TB] FAIL rand_count it=%0d: got %0d expected %0d", it, ti, expData.size()); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < DEPTH; a++) writeWord(a, $urandom);
    st_data_rdy = 1'b1;
    startCmd(4, 0);
    tick();
    tick();
    tick();
    checks++;
    if (st_data_vld !== 1'b1 || st_data !== modelMem[2]) begin
      fails++;
      $display("[TB] FAIL rmid_word2: got vld=%b data=%h expected vld=1 data=%h", st_data_vld, st_data, modelMem[2]);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (st_data_vld !== 1'b0 || busy !== 1'b0 || st_data_fst !== 1'b0 || st_data !== '0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rmid_async: got vld=%b busy=%b fst=%b data=%h done=%b expected all 0",
               st_data_vld, busy, st_data_fst, st_data, done);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (st_data_vld !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL rmid_no_resume[%0d]: got vld=%b busy=%b expected vld=0 busy=0", i, st_data_vld, busy);
      end
    end
    buildExpected(20, 0);
    startCmd(20, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (st_data_vld !== 1'b1 || st_data !== expData[i] || st_data_fst !== expFst[i]) begin
        fails++;
        $display("[TB] FAIL clamp_word[%0d]: got vld=%b data=%h fst=%b expected vld=1 data=%h fst=%b",
                 i, st_data_vld, st_data, st_data_fst, expData[i], expFst[i]);
      end
    end
    tick();
    checks++;
    if (st_data_vld !== 1'b0 || done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL clamp_done: got vld=%b done=%b expected vld=0 done=1", st_data_vld, done);
    end
    tick();
  endtask

  initial begin
    reset       = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    frame_len   = '0;
    repeat_cnt  = '0;
    start       = 1'b0;
    st_data_rdy = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_repeat();
    test_backpressure();
    test_zero_len();
    test_write_during_send();
    test_random_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
